// File: rtl/axi_node_pkg.sv
// Shared types and helpers for the AXI node: AR router state encoding and
// the priority encoder used by the address decoders.
package axi_node_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ERR_WAIT = 2'd1,
    ERR_REQ  = 2'd2
  } ar_route_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int unsigned first_one(input logic [31:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/axi_addr_decoder.sv
// Combinational address-map lookup: inclusive region match per initiator,
// lowest-index region wins on overlap.
module axi_addr_decoder
  import axi_node_pkg::*;
#(
  parameter int AXI_ADDR_W  = 32,
  parameter int N_INIT_PORT = 4,
  parameter int LOG_N_INIT  = 2
) (
  input  logic [AXI_ADDR_W-1:0]             addr,
  input  logic [N_INIT_PORT*AXI_ADDR_W-1:0] start_addr,
  input  logic [N_INIT_PORT*AXI_ADDR_W-1:0] end_addr,
  input  logic [N_INIT_PORT-1:0]            valid_rule,
  output logic [N_INIT_PORT-1:0]            dest_oh,
  output logic [LOG_N_INIT-1:0]             dest_idx,
  output logic                              miss
);

  logic [N_INIT_PORT-1:0] match;

  always_comb begin
    match = '0;
    for (int k = 0; k < N_INIT_PORT; k++) begin
      match[k] = valid_rule[k] &&
                 (addr >= start_addr[k*AXI_ADDR_W +: AXI_ADDR_W]) &&
                 (addr <= end_addr[k*AXI_ADDR_W +: AXI_ADDR_W]);
    end
  end

  assign miss     = ~|match;
  assign dest_idx = LOG_N_INIT'(first_one(32'(match)));
  assign dest_oh  = miss ? '0 : (N_INIT_PORT'(1) << dest_idx);

endmodule

// File: rtl/axi_ar_route_ctrl.sv
// Per-target-port AR router: forwards mapped reads to one initiator and turns
// unmapped reads into a locally generated error burst once reads have drained.
module axi_ar_route_ctrl
  import axi_node_pkg::*;
#(
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_ID_IN   = 16,
  parameter int AXI_USER_W  = 6,
  parameter int N_INIT_PORT = 4,
  parameter int N_TARG_PORT = 7,
  parameter int TARG_IDX    = 0,
  parameter int AXI_ID_OUT  = AXI_ID_IN + ((N_TARG_PORT > 1) ? $clog2(N_TARG_PORT) : 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [AXI_ADDR_W-1:0]             araddr_i,
  input  logic [7:0]                        arlen_i,
  input  logic [AXI_ID_IN-1:0]              arid_i,
  input  logic [AXI_USER_W-1:0]             aruser_i,
  input  logic                              arvalid_i,
  output logic                              arready_o,
  input  logic [N_INIT_PORT*AXI_ADDR_W-1:0] start_addr_i,
  input  logic [N_INIT_PORT*AXI_ADDR_W-1:0] end_addr_i,
  input  logic [N_INIT_PORT-1:0]            valid_rule_i,
  output logic [AXI_ADDR_W-1:0]             araddr_o,
  output logic [7:0]                        arlen_o,
  output logic [AXI_USER_W-1:0]             aruser_o,
  output logic [AXI_ID_OUT-1:0]             arid_o,
  output logic [N_INIT_PORT-1:0]            arvalid_o,
  input  logic [N_INIT_PORT-1:0]            arready_i,
  output logic                              incr_req_o,
  input  logic                              full_counter_i,
  input  logic                              outstanding_trans_i,
  output logic                              error_req_o,
  input  logic                              error_gnt_i,
  output logic [7:0]                        error_len_o,
  output logic [AXI_ID_IN-1:0]              error_id_o,
  output logic [AXI_USER_W-1:0]             error_user_o,
  output logic                              sample_ardata_info_o,
  output logic [1:0]                        cs_o
);

  // Handshake: an AR transfers on a cycle where valid and ready are both high;
  // valid, once raised, holds with stable fields until ready is seen.

  localparam int LOG_N_TARG = (N_TARG_PORT > 1) ? $clog2(N_TARG_PORT) : 1;
  localparam int LOG_N_INIT = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;
  localparam logic [LOG_N_TARG-1:0] TARG_ID = LOG_N_TARG'(TARG_IDX);

  ar_route_state_e         cs;
  logic [LOG_N_INIT-1:0]   last_dest;
  logic [7:0]              err_len;
  logic [AXI_ID_IN-1:0]    err_id;
  logic [AXI_USER_W-1:0]   err_user;
  logic                    fwd_hold;

  logic [N_INIT_PORT-1:0]  dest_oh;
  logic [LOG_N_INIT-1:0]   dest_idx;
  logic                    miss;
  logic                    blocked;

  axi_addr_decoder #(
    .AXI_ADDR_W  (AXI_ADDR_W),
    .N_INIT_PORT (N_INIT_PORT),
    .LOG_N_INIT  (LOG_N_INIT)
  ) u_dec (
    .addr       (araddr_i),
    .start_addr (start_addr_i),
    .end_addr   (end_addr_i),
    .valid_rule (valid_rule_i),
    .dest_oh    (dest_oh),
    .dest_idx   (dest_idx),
    .miss       (miss)
  );

  assign araddr_o = araddr_i;
  assign arlen_o  = arlen_i;
  assign aruser_o = aruser_i;
  assign arid_o   = AXI_ID_OUT'({TARG_ID, arid_i});
  assign cs_o     = cs;

  // While idle the error fields mirror the incoming AR so they are valid on the
  // capture pulse; afterwards they come from the captured copy.
  assign error_len_o  = (cs == IDLE) ? arlen_i  : err_len;
  assign error_id_o   = (cs == IDLE) ? arid_i   : err_id;
  assign error_user_o = (cs == IDLE) ? aruser_i : err_user;

  always_comb begin
    arvalid_o            = '0;
    arready_o            = 1'b0;
    incr_req_o           = 1'b0;
    sample_ardata_info_o = 1'b0;
    error_req_o          = 1'b0;
    blocked = full_counter_i | (outstanding_trans_i & (dest_idx != last_dest));
    if (rst_n) begin
      case (cs)
        IDLE: begin
          if (!miss) begin
            // A request already presented is never withdrawn by a late block.
            if (fwd_hold || !blocked) begin
              arvalid_o  = dest_oh & {N_INIT_PORT{arvalid_i}};
              arready_o  = |(arready_i & dest_oh);
              incr_req_o = arvalid_i & arready_o;
            end
          end else if (arvalid_i) begin
            arready_o            = 1'b1;
            sample_ardata_info_o = 1'b1;
          end
        end
        ERR_REQ: error_req_o = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs        <= IDLE;
      last_dest <= '0;
      err_len   <= '0;
      err_id    <= '0;
      err_user  <= '0;
      fwd_hold  <= 1'b0;
    end else begin
      fwd_hold <= (|arvalid_o) & ~arready_o;
      case (cs)
        IDLE: begin
          if (incr_req_o) begin
            last_dest <= dest_idx;
          end else if (sample_ardata_info_o) begin
            err_len  <= arlen_i;
            err_id   <= arid_i;
            err_user <= aruser_i;
            cs       <= outstanding_trans_i ? ERR_WAIT : ERR_REQ;
          end
        end
        ERR_WAIT: if (!outstanding_trans_i) cs <= ERR_REQ;
        ERR_REQ:  if (error_gnt_i) cs <= IDLE;
        default:  cs <= IDLE;
      endcase
    end
  end

endmodule
